pq_sched: RTL



---
 rtl/pq_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pq_sched.sv
// Round-robin enqueue scheduler and head-exposing consumer port for a shared
// shift-register priority queue, with power-up reset sequencing and drain-flush.
package pq_pkg;
    localparam int unsigned KEY_WIDTH = 8;
    localparam int unsigned VAL_WIDTH = 8;
endpackage

module pq_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned KW    = pq_pkg::KEY_WIDTH,
    parameter int unsigned VW    = pq_pkg::VAL_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_REQ-1:0]                 req_valid,
    input  logic [N_REQ*(KW+VW)-1:0]         req_kv,
    output logic [N_REQ-1:0]                 req_ready,
    output logic                             out_valid,
    output logic [KW+VW-1:0]                 out_kv,
    input  logic                             out_ready,
    input  logic                             flush,
    output logic                             busy,
    output logic [$clog2(DEPTH+1)-1:0]       occ,
    output logic                             err,
    output logic                             pq_rst,
    output logic                             pq_enq,
    output logic                             pq_deq,
    output logic [KW+VW-1:0]                 pq_kvi,
    input  logic [KW+VW-1:0]                 pq_kvo,
    input  logic                             pq_empty,
    input  logic                             pq_full
);

    localparam int unsigned EW = KW + VW;
    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_init_cnt;
    logic [PW-1:0]   r_rr;
    logic [OW-1:0]   r_occ;
    logic            r_err;

    logic [EW-1:0]   w_kv [N_REQ];
    logic            w_win_found;
    logic [PW-1:0]   w_win_idx;
    logic [PW-1:0]   w_cand;
    logic            w_head_ok;
    logic            w_take;
    logic            w_enq_ok;

    // Unpack the flat requester bus into per-requester entries.
    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
        assign w_kv[g] = req_kv[g*EW +: EW];
    end

    // Cyclic search from r_rr; walking backwards leaves the nearest requester last.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            w_cand = PW'((int'(r_rr) + k) % int'(N_REQ));
            if (req_valid[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    assign w_head_ok = !pq_empty && !flush;
    assign w_take    = w_head_ok && out_ready;
    assign w_enq_ok  = !flush && (!pq_full || w_take);

    // Next state and queue/handshake controls.
    always_comb begin
        w_state_nxt = r_state;
        pq_rst      = 1'b0;
        pq_enq      = 1'b0;
        pq_deq      = 1'b0;
        req_ready   = '0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_INIT: begin
                pq_rst = 1'b1;
                busy   = 1'b1;
                if (r_init_cnt) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                out_valid = w_head_ok;
                pq_deq    = w_take;
                if (w_enq_ok && w_win_found) begin
                    req_ready = N_REQ'(1) << w_win_idx;
                    pq_enq    = 1'b1;
                end
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy   = 1'b1;
                pq_deq = !pq_empty;
                if (pq_empty && (r_occ == '0)) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                pq_rst      = 1'b1;
                busy        = 1'b1;
            end
        endcase
    end

    assign pq_kvi = w_kv[w_win_idx];
    assign out_kv = pq_kvo;
    assign occ    = r_occ;
    assign err    = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= (r_state == S_INIT) ? (r_init_cnt + 1'b1) : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr <= '0;
        end else if (pq_enq) begin
            r_rr <= (w_win_idx == PW'(N_REQ - 1)) ? '0 : (w_win_idx + PW'(1));
        end
    end

    // Occupancy tracking; a step past 0 or DEPTH leaves occ alone and flags err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
            r_err <= 1'b0;
        end else begin
            case ({pq_enq, pq_deq})
                2'b10: begin
                    if (r_occ == OW'(DEPTH)) r_err <= 1'b1;
                    else                     r_occ <= r_occ + OW'(1);
                end
                2'b01: begin
                    if (r_occ == '0) r_err <= 1'b1;
                    else             r_occ <= r_occ - OW'(1);
                end
                default: ;
            endcase
            if ((r_state != S_INIT) &&
                ((pq_full != (r_occ == OW'(DEPTH))) || (pq_empty != (r_occ == '0)))) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
